// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped data cache.
// Holds the controller state encoding, the default geometry and the derived
// tag width used by dcache_ctrl and dcache_array.
package cache_pkg;

  localparam int LINE_NUM_WIDTH_DEF = 3;
  localparam int ADDR_WIDTH_DEF     = 32;
  localparam int WORD_W             = 32;
  localparam int TAG_WIDTH_DEF      = ADDR_WIDTH_DEF - LINE_NUM_WIDTH_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2
  } state_t;

endpackage

// File: rtl/dcache_array.sv
// Line storage for the direct-mapped data cache.
// Each line holds valid, dirty, tag and one data word.
//   clk, rst           : clock, synchronous active-low reset (clears valid/dirty only)
//   rd_idx             : async read index; rd_valid/rd_dirty/rd_tag/rd_data out
//   wr_en, wr_idx      : synchronous full-line write (valid is set, dirty = wr_dirty)
//   wr_dirty, wr_tag, wr_data : contents of the written line
//   clr_dirty_en, clr_idx     : synchronous dirty clear for one line
module dcache_array
  import cache_pkg::*;
#(
  parameter int LINE_NUM_WIDTH = LINE_NUM_WIDTH_DEF,
  parameter int TAG_W          = TAG_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LINE_NUM_WIDTH-1:0] rd_idx,
  output logic                      rd_valid,
  output logic                      rd_dirty,
  output logic [TAG_W-1:0]          rd_tag,
  output logic [WORD_W-1:0]         rd_data,
  input  logic                      wr_en,
  input  logic [LINE_NUM_WIDTH-1:0] wr_idx,
  input  logic                      wr_dirty,
  input  logic [TAG_W-1:0]          wr_tag,
  input  logic [WORD_W-1:0]         wr_data,
  input  logic                      clr_dirty_en,
  input  logic [LINE_NUM_WIDTH-1:0] clr_idx
);

  localparam int LINES = 1 << LINE_NUM_WIDTH;

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [WORD_W-1:0] data_q [LINES];

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (wr_en) begin
        valid_q[wr_idx] <= 1'b1;
        dirty_q[wr_idx] <= wr_dirty;
      end
      if (clr_dirty_en) begin
        dirty_q[clr_idx] <= 1'b0;
      end
    end
  end

  // Tag and data carry no reset; a line is meaningless until valid is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller, one-word lines.
// Serves hits with no wait cycles; on a miss writes back a dirty victim and
// fills the line over the RAM ren/wen/ack handshake while stalling the CPU.
//   clk, rst                     : clock, synchronous active-low reset
//   cpu_addr/ren/wen/din         : MEM-stage request (ren&wen counts as store)
//   cpu_dout, cpu_stall          : hit data (0 when not hitting), pipeline freeze
//   mem_addr/ren/wen/dout        : registered RAM request, held until mem_ack
//   mem_din, mem_ack             : RAM read data and one-cycle completion pulse
//   hit_cnt, miss_cnt            : statistics counters
// Build option: define DCACHE_STATS_EN to enable the counters; otherwise both
// counter outputs are tied to zero.
module dcache_ctrl
  import cache_pkg::*;
#(
  parameter int LINE_NUM_WIDTH = LINE_NUM_WIDTH_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_ren,
  input  logic                  cpu_wen,
  input  logic [WORD_W-1:0]     cpu_din,
  output logic [WORD_W-1:0]     cpu_dout,
  output logic                  cpu_stall,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_ren,
  output logic                  mem_wen,
  output logic [WORD_W-1:0]     mem_dout,
  input  logic [WORD_W-1:0]     mem_din,
  input  logic                  mem_ack,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
);

  localparam int TAG_W = ADDR_WIDTH - LINE_NUM_WIDTH;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] miss_addr_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  mem_ren_q;
  logic                  mem_wen_q;
  logic [WORD_W-1:0]     mem_dout_q;

  logic [LINE_NUM_WIDTH-1:0] cpu_idx, miss_idx;
  logic [TAG_W-1:0]          cpu_tag, miss_tag;

  logic              rd_valid, rd_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [WORD_W-1:0] rd_data;

  logic                      wr_en, wr_dirty, clr_dirty_en;
  logic [LINE_NUM_WIDTH-1:0] wr_idx;
  logic [TAG_W-1:0]          wr_tag;
  logic [WORD_W-1:0]         wr_data;

  logic req, hit, idle_miss, wb_done, fill_done;

  assign cpu_idx  = cpu_addr[LINE_NUM_WIDTH-1:0];
  assign cpu_tag  = cpu_addr[ADDR_WIDTH-1:LINE_NUM_WIDTH];
  assign miss_idx = miss_addr_q[LINE_NUM_WIDTH-1:0];
  assign miss_tag = miss_addr_q[ADDR_WIDTH-1:LINE_NUM_WIDTH];

  // The CPU request is held stable during a stall, so the array can always be
  // read at the CPU index; the victim fields are captured when the miss starts.
  dcache_array #(
    .LINE_NUM_WIDTH(LINE_NUM_WIDTH),
    .TAG_W         (TAG_W)
  ) u_array (
    .clk         (clk),
    .rst         (rst),
    .rd_idx      (cpu_idx),
    .rd_valid    (rd_valid),
    .rd_dirty    (rd_dirty),
    .rd_tag      (rd_tag),
    .rd_data     (rd_data),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_dirty    (wr_dirty),
    .wr_tag      (wr_tag),
    .wr_data     (wr_data),
    .clr_dirty_en(clr_dirty_en),
    .clr_idx     (miss_idx)
  );

  assign req       = cpu_ren | cpu_wen;
  assign hit       = rd_valid & (rd_tag == cpu_tag);
  assign idle_miss = (state_q == IDLE) & req & ~hit;
  // Acks only count while our own request is up; stray pulses are dropped.
  assign wb_done   = (state_q == WB)   & mem_wen_q & mem_ack;
  assign fill_done = (state_q == FILL) & mem_ren_q & mem_ack;

  assign mem_addr = mem_addr_q;
  assign mem_ren  = mem_ren_q;
  assign mem_wen  = mem_wen_q;
  assign mem_dout = mem_dout_q;

  always_comb begin
    state_d      = state_q;
    cpu_stall    = 1'b0;
    cpu_dout     = '0;
    wr_en        = 1'b0;
    wr_idx       = cpu_idx;
    wr_dirty     = 1'b1;
    wr_tag       = cpu_tag;
    wr_data      = cpu_din;
    clr_dirty_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit) begin
          cpu_dout = rd_data;
        end
        if (req && hit && cpu_wen) begin
          wr_en = 1'b1;
        end
        if (idle_miss) begin
          cpu_stall = 1'b1;
          state_d   = (rd_valid && rd_dirty) ? WB : FILL;
        end
      end
      WB: begin
        cpu_stall = 1'b1;
        if (wb_done) begin
          clr_dirty_en = 1'b1;
          state_d      = FILL;
        end
      end
      FILL: begin
        cpu_stall = 1'b1;
        if (fill_done) begin
          wr_en    = 1'b1;
          wr_idx   = miss_idx;
          wr_dirty = 1'b0;
          wr_tag   = miss_tag;
          wr_data  = mem_din;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      mem_addr_q  <= '0;
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_dout_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (idle_miss) begin
            miss_addr_q <= cpu_addr;
            if (rd_valid && rd_dirty) begin
              mem_wen_q  <= 1'b1;
              mem_addr_q <= {rd_tag, cpu_idx};
              mem_dout_q <= rd_data;
            end else begin
              mem_ren_q  <= 1'b1;
              mem_addr_q <= cpu_addr;
            end
          end
        end
        WB: begin
          if (wb_done) begin
            mem_wen_q <= 1'b0;
          end
        end
        FILL: begin
          // After a writeback the bus sits idle for one cycle before the
          // read is raised, so ren never follows wen on the same edge.
          if (fill_done) begin
            mem_ren_q <= 1'b0;
          end else if (!mem_ren_q) begin
            mem_ren_q  <= 1'b1;
            mem_addr_q <= miss_addr_q;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // The completion cycle after a fill is an IDLE hit and is counted as such.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if ((state_q == IDLE) && req && hit) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (idle_miss) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed testbench for dcache_ctrl with a fixed-delay RAM responder.
module tb_dcache_ctrl;

  localparam int D = 3;  // RAM delay: request cycles up to and including ack

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic        cpu_ren = 1'b0;
  logic        cpu_wen = 1'b0;
  logic [31:0] cpu_din = '0;
  logic [31:0] cpu_dout;
  logic        cpu_stall;
  logic [31:0] mem_addr;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_dout;
  logic [31:0] mem_din = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] hit_cnt, miss_cnt;

  int checks = 0;
  int passed = 0;

  dcache_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_addr (cpu_addr),
    .cpu_ren  (cpu_ren),
    .cpu_wen  (cpu_wen),
    .cpu_din  (cpu_din),
    .cpu_dout (cpu_dout),
    .cpu_stall(cpu_stall),
    .mem_addr (mem_addr),
    .mem_ren  (mem_ren),
    .mem_wen  (mem_wen),
    .mem_dout (mem_dout),
    .mem_din  (mem_din),
    .mem_ack  (mem_ack),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  always #5 clk = ~clk;

  // RAM responder: read data is {16'hA5A5, addr[15:0]}; writes are logged.
  int          cnt = 0;
  int          rd_count = 0;
  int          wr_count = 0;
  logic [31:0] rd_log_addr = '0;
  logic [31:0] wr_log_addr = '0;
  logic [31:0] wr_log_data = '0;

  always @(posedge clk) begin
    if (mem_ack) begin
      mem_ack <= 1'b0;
      cnt     <= 0;
      if (mem_wen) begin
        wr_count    <= wr_count + 1;
        wr_log_addr <= mem_addr;
        wr_log_data <= mem_dout;
      end
      if (mem_ren) begin
        rd_count    <= rd_count + 1;
        rd_log_addr <= mem_addr;
      end
    end else if (mem_ren || mem_wen) begin
      if (cnt == D - 2) begin
        mem_ack <= 1'b1;
        mem_din <= {16'hA5A5, mem_addr[15:0]};
      end
      cnt <= cnt + 1;
    end else begin
      cnt <= 0;
    end
  end

  // Bus-rule monitor: no ren&wen overlap, stable address while requesting,
  // request gone the cycle after ack.
  int          viol = 0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (mem_ren && mem_wen) viol = viol + 1;
      if ((mem_ren || mem_wen) && prev_req && !prev_ack && (mem_addr != prev_addr)) viol = viol + 1;
      if ((mem_ren || mem_wen) && prev_req && prev_ack) viol = viol + 1;
    end
    prev_req  = mem_ren | mem_wen;
    prev_ack  = mem_ack;
    prev_addr = mem_addr;
  end

  task automatic access(input logic [31:0] a, input logic r, input logic w,
                        input logic [31:0] d, output int stalls, output logic [31:0] dout);
    @(negedge clk);
    cpu_addr = a; cpu_ren = r; cpu_wen = w; cpu_din = d;
    #1;
    stalls = 0;
    while (cpu_stall && stalls < 200) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    dout = cpu_dout;
    @(posedge clk);
    #1;
    cpu_ren = 1'b0; cpu_wen = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mem_ren !== 1'b0) $display("FAIL reset_mem_ren: got %b expected 0", mem_ren); else passed++;
    checks++; if (mem_wen !== 1'b0) $display("FAIL reset_mem_wen: got %b expected 0", mem_wen); else passed++;
    checks++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); else passed++;
    checks++; if (mem_dout !== 32'h0) $display("FAIL reset_mem_dout: got %h expected 0", mem_dout); else passed++;
    checks++; if (cpu_stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", cpu_stall); else passed++;
    checks++; if (hit_cnt !== 32'h0) $display("FAIL reset_hit_cnt: got %0d expected 0", hit_cnt); else passed++;
    checks++; if (miss_cnt !== 32'h0) $display("FAIL reset_miss_cnt: got %0d expected 0", miss_cnt); else passed++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_clean_miss();
    int s; logic [31:0] d; int r0;
    r0 = rd_count;
    access(32'h3, 1'b1, 1'b0, 32'h0, s, d);
    checks++; if (s !== D + 1) $display("FAIL clean_miss_stalls: got %0d expected %0d", s, D + 1); else passed++;
    checks++; if (d !== 32'hA5A5_0003) $display("FAIL clean_miss_data: got %h expected a5a50003", d); else passed++;
    checks++; if (rd_count !== r0 + 1) $display("FAIL clean_miss_reads: got %0d expected %0d", rd_count, r0 + 1); else passed++;
    checks++; if (rd_log_addr !== 32'h3) $display("FAIL clean_miss_addr: got %h expected 3", rd_log_addr); else passed++;
    access(32'h3, 1'b1, 1'b0, 32'h0, s, d);
    checks++; if (s !== 0) $display("FAIL reload_stalls: got %0d expected 0", s); else passed++;
    checks++; if (d !== 32'hA5A5_0003) $display("FAIL reload_data: got %h expected a5a50003", d); else passed++;
  endtask

  task automatic test_write_hit();
    int s; logic [31:0] d; int w0;
    w0 = wr_count;
    access(32'h3, 1'b0, 1'b1, 32'hDEAD_BEEF, s, d);
    checks++; if (s !== 0) $display("FAIL write_hit_stalls: got %0d expected 0", s); else passed++;
    access(32'h3, 1'b1, 1'b0, 32'h0, s, d);
    checks++; if (d !== 32'hDEAD_BEEF) $display("FAIL write_hit_readback: got %h expected deadbeef", d); else passed++;
    checks++; if (wr_count !== w0) $display("FAIL write_hit_no_wen: got %0d expected %0d", wr_count, w0); else passed++;
  endtask

  task automatic test_dirty_miss();
    int s; logic [31:0] d; int w0;
    w0 = wr_count;
    access(32'hB, 1'b1, 1'b0, 32'h0, s, d);
    checks++; if (s !== 2 * D + 2) $display("FAIL dirty_miss_stalls: got %0d expected %0d", s, 2 * D + 2); else passed++;
    checks++; if (wr_count !== w0 + 1) $display("FAIL dirty_miss_writes: got %0d expected %0d", wr_count, w0 + 1); else passed++;
    checks++; if (wr_log_addr !== 32'h3) $display("FAIL wb_addr: got %h expected 3", wr_log_addr); else passed++;
    checks++; if (wr_log_data !== 32'hDEAD_BEEF) $display("FAIL wb_data: got %h expected deadbeef", wr_log_data); else passed++;
    checks++; if (rd_log_addr !== 32'hB) $display("FAIL dirty_fill_addr: got %h expected b", rd_log_addr); else passed++;
    checks++; if (d !== 32'hA5A5_000B) $display("FAIL dirty_miss_data: got %h expected a5a5000b", d); else passed++;
  endtask

  task automatic test_store_miss();
    int s; logic [31:0] d;
    access(32'h14, 1'b0, 1'b1, 32'h1234, s, d);
    checks++; if (s !== D + 1) $display("FAIL store_miss_stalls: got %0d expected %0d", s, D + 1); else passed++;
    checks++; if (rd_log_addr !== 32'h14) $display("FAIL store_miss_fill_addr: got %h expected 14", rd_log_addr); else passed++;
    access(32'h14, 1'b1, 1'b0, 32'h0, s, d);
    checks++; if (d !== 32'h1234) $display("FAIL store_miss_merge: got %h expected 1234", d); else passed++;
    access(32'h1C, 1'b1, 1'b0, 32'h0, s, d);
    checks++; if (s !== 2 * D + 2) $display("FAIL store_victim_stalls: got %0d expected %0d", s, 2 * D + 2); else passed++;
    checks++; if (wr_log_addr !== 32'h14) $display("FAIL store_victim_addr: got %h expected 14", wr_log_addr); else passed++;
    checks++; if (wr_log_data !== 32'h1234) $display("FAIL store_victim_data: got %h expected 1234", wr_log_data); else passed++;
  endtask

  task automatic test_ren_wen_both();
    int s; logic [31:0] d; int r0; int w0;
    r0 = rd_count; w0 = wr_count;
    access(32'h1C, 1'b1, 1'b1, 32'h55, s, d);
    checks++; if (s !== 0) $display("FAIL both_stalls: got %0d expected 0", s); else passed++;
    access(32'h1C, 1'b1, 1'b0, 32'h0, s, d);
    checks++; if (d !== 32'h55) $display("FAIL both_as_store: got %h expected 55", d); else passed++;
    checks++; if (rd_count + wr_count !== r0 + w0) $display("FAIL both_no_mem: got %0d expected %0d", rd_count + wr_count, r0 + w0); else passed++;
  endtask

  task automatic test_reset_mid_fill();
    int s; logic [31:0] d; int r0;
    r0 = rd_count;
    @(negedge clk);
    cpu_addr = 32'h25; cpu_ren = 1'b1;
    @(negedge clk);
    checks++; if (mem_ren !== 1'b1) $display("FAIL mid_fill_ren_up: got %b expected 1", mem_ren); else passed++;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (mem_ren !== 1'b0) $display("FAIL mid_fill_ren_drop: got %b expected 0", mem_ren); else passed++;
    checks++; if (mem_addr !== 32'h0) $display("FAIL mid_fill_addr_clr: got %h expected 0", mem_addr); else passed++;
    cpu_ren = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    access(32'h25, 1'b1, 1'b0, 32'h0, s, d);
    checks++; if (s !== D + 1) $display("FAIL mid_fill_remiss: got %0d expected %0d", s, D + 1); else passed++;
    checks++; if (rd_count !== r0 + 1) $display("FAIL mid_fill_reads: got %0d expected %0d", rd_count, r0 + 1); else passed++;
    checks++; if (d !== 32'hA5A5_0025) $display("FAIL mid_fill_data: got %h expected a5a50025", d); else passed++;
  endtask

  task automatic test_stats();
    int s; logic [31:0] d;
    logic [31:0] exp_hit, exp_miss;
`ifdef DCACHE_STATS_EN
    exp_hit = 32'd4; exp_miss = 32'd2;
`else
    exp_hit = 32'd0; exp_miss = 32'd0;
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    access(32'h6, 1'b1, 1'b0, 32'h0, s, d);        // miss + post-fill hit
    access(32'h6, 1'b0, 1'b1, 32'hCAFE, s, d);     // hit, line dirty
    access(32'h6, 1'b1, 1'b0, 32'h0, s, d);        // hit
    access(32'hE, 1'b1, 1'b0, 32'h0, s, d);        // dirty miss + post-fill hit
    checks++; if (s !== 2 * D + 2) $display("FAIL stats_dirty_stalls: got %0d expected %0d", s, 2 * D + 2); else passed++;
    checks++; if (hit_cnt !== exp_hit) $display("FAIL stats_hit_cnt: got %0d expected %0d", hit_cnt, exp_hit); else passed++;
    checks++; if (miss_cnt !== exp_miss) $display("FAIL stats_miss_cnt: got %0d expected %0d", miss_cnt, exp_miss); else passed++;
  endtask

  task automatic test_handshake_rules();
    checks++; if (viol !== 0) $display("FAIL bus_rules: got %0d violations expected 0", viol); else passed++;
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_write_hit();
    test_dirty_miss();
    test_store_miss();
    test_ren_wen_both();
    test_reset_mid_fill();
    test_stats();
    test_handshake_rules();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller with one-word lines.
- Sits between the pipeline MEM stage and the multi-cycle data RAM. It serves hits in zero wait cycles and stalls the pipeline on a miss.
- On a miss it writes back a dirty victim, then fills the line using the RAM's ren/wen/ack handshake.

Parameters:
- LINE_NUM_WIDTH, 3, index bits; the cache holds 1<<LINE_NUM_WIDTH lines.
- ADDR_WIDTH, 32, word-address width on both the CPU and memory sides.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset.
- cpu_addr  in  32  word address from the MEM stage.
- cpu_ren  in  1  load request.
- cpu_wen  in  1  store request.
- cpu_din  in  32  store data.
- cpu_dout  out  32  load data; combinational on a hit, 0 otherwise.
- cpu_stall  out  1  freezes the pipeline.
- mem_addr  out  32  address to the data RAM.
- mem_ren  out  1  RAM read request.
- mem_wen  out  1  RAM write request.
- mem_dout  out  32  write data to the RAM.
- mem_din  in  32  read data from the RAM.
- mem_ack  in  1  one-cycle completion pulse from the RAM.
- hit_cnt  out  32  hit counter (see Optional Feature).
- miss_cnt  out  32  miss counter (see Optional Feature).

Behaviour:
- Address split: idx = addr[LINE_NUM_WIDTH-1:0]; tag = addr[ADDR_WIDTH-1:LINE_NUM_WIDTH].
- Per-line storage: valid, dirty, tag and 32-bit data.
- hit = valid[idx] & (tag match), evaluated combinationally on cpu_addr.
- cpu_ren and cpu_wen both high: treat as a store.
- Reset (rst==0 at posedge):
  - state=IDLE.
  - All valid and dirty bits cleared; data and tag arrays are not cleared.
  - mem_ren=mem_wen=0, mem_addr=0, mem_dout=0.
  - Counters=0.
  - Reset mid-transaction abandons it. The RAM drops its pending request because ren/wen fall.
- State IDLE:
  - cpu_stall = (cpu_ren|cpu_wen) & ~hit.
  - Read hit: cpu_dout=line data, no state change.
  - Write hit: at posedge, data<=cpu_din and dirty<=1.
  - Miss: latch miss_addr<=cpu_addr. Go to WB if the victim is valid & dirty, otherwise go to FILL.
- State WB:
  - mem_wen=1, mem_addr={victim tag, idx}, mem_dout=victim data. All are registered and held constant until ack.
  - cpu_stall=1.
  - On mem_ack: clear dirty and go to FILL.
- State FILL:
  - mem_ren=1, mem_addr=miss_addr, held constant until ack.
  - cpu_stall=1.
  - On mem_ack, line[idx]: data<=mem_din, tag<=miss tag, valid<=1, dirty<=0. Then go to IDLE.
- Return to IDLE: the held CPU request now hits. The original access completes in that cycle and the stall drops.
- Handshake rules:
  - mem_ren and mem_wen are never high together.
  - mem_addr never changes while a request is high; the RAM restarts its delay on any address change.
  - mem_ren/mem_wen deassert on the posedge that samples mem_ack.
- CPU side rule: cpu_addr/cpu_ren/cpu_wen/cpu_din must stay stable while cpu_stall=1. The controller uses miss_addr so it tolerates violation, but results are then undefined.
- mem_ack seen in IDLE: ignored.
- Latency:
  - Hit: 0 stall cycles.
  - Clean miss: RAM delay + 1 cycles.
  - Dirty miss: two RAM delays + 2 cycles.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined:
  - hit_cnt increments once per IDLE cycle with a request and a hit.
  - miss_cnt increments once on each IDLE->WB or IDLE->FILL transition.
  - The post-fill completion cycle counts as a hit.
  - Both counters wrap modulo 2^32 and clear on reset.
- Undefined: hit_cnt and miss_cnt are tied to 0 and no counter logic is synthesized.

Decomposition:
- Shared package cache_pkg holds:
  - State encoding: IDLE=2'd0, WB=2'd1, FILL=2'd2.
  - LINE_NUM_WIDTH default.
  - Tag-width derivation constant.
- One natural sub-module, dcache_array: valid/dirty/tag/data storage with an async read port and a synchronous write port. The FSM stays in dcache_ctrl.

Test Plan:
- After reset, load addr 0x3 -> stall high. One FILL with mem_addr=0x3 and mem_ren held. On ack with mem_din=0xA5A5_0003 the stall drops and cpu_dout=0xA5A5_0003. Re-load 0x3 -> 0 stall cycles.
- Store 0xDEAD_BEEF to 0x3, which hits -> no stall and no mem_wen. Load 0x3 returns 0xDEAD_BEEF.
- Then load 0xB (same idx 3, different tag) -> WB: mem_wen with mem_addr=0x3, mem_dout=0xDEAD_BEEF. Then FILL with mem_addr=0xB. Total stall = 2×delay+2.
- Store miss to 0x14 with cpu_din=0x1234 -> FILL reads 0x14, then the write merges. Line dirty=1, and a following conflicting access triggers a writeback of 0x1234.
- Drive rst low during FILL -> next cycle mem_ren=0 and state IDLE. A load of the same address misses again.
- With DCACHE_STATS_EN, run the sequence: miss, hit, hit, dirty miss -> hit_cnt=4 (including 2 post-fill cycles), miss_cnt=2. Without the macro both read 0.
